dw_mac_unit: RTL and testbench

DW_MAC_UNIT -- requirements
Module: dw_mac_unit

---
 rtl/dw_pkg.sv | 15 +
 rtl/dw_weight_rf.sv | 30 +++
 rtl/dw_mac_unit.sv | 131 +++++++++++++
 tb/tb_dw_mac_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dw_pkg.sv
// Shared types and default sizing for the depthwise MAC unit.
package dw_pkg;

  localparam int DwDefault   = 16;
  localparam int KkDefault   = 9;
  localparam int AccWDefault = 40;

  typedef enum logic [1:0] {
    StIdle,
    StLoadW,
    StCompute,
    StOutput
  } dw_state_e;

endpackage

// File: rtl/dw_weight_rf.sv
// KK-entry weight register file: one synchronous write port, one combinational read port.
module dw_weight_rf #(
  parameter int DW = 16,
  parameter int KK = 9,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [KK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KK; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dw_mac_unit.sv
// Depthwise 3x3 MAC: loads a kernel of KK weights, then produces one signed dot product
// per window of KK activations, with a stall-able result handshake.
module dw_mac_unit
  import dw_pkg::*;
#(
  parameter int DW    = DwDefault,
  parameter int KK    = KkDefault,
  parameter int ACC_W = AccWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             weight_load,
  input  logic [DW-1:0]    w_data,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [DW-1:0]    act_data,
  input  logic             act_valid,
  output logic             act_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int AW = (KK > 1) ? $clog2(KK) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(KK - 1);

  dw_state_e         state_q;
  logic [AW-1:0]     wcnt_q;
  logic [AW-1:0]     acnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_out_q;
  logic              out_valid_q;
  logic              weight_load_q;

  logic [DW-1:0]         w_rd;
  logic signed [2*DW-1:0] prod;
  logic [ACC_W-1:0]      prod_ext;
  logic [ACC_W-1:0]      acc_sum;

  dw_weight_rf #(
    .DW (DW),
    .KK (KK),
    .AW (AW)
  ) u_weight_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    ((state_q == StLoadW) && w_valid),
    .waddr_i (wcnt_q),
    .wdata_i (w_data),
    .raddr_i (acnt_q),
    .rdata_o (w_rd)
  );

  // Operands are sign-extended to the full product width so the multiply is exact.
  always_comb begin
    prod     = $signed({{DW{act_data[DW-1]}}, act_data}) * $signed({{DW{w_rd[DW-1]}}, w_rd});
    prod_ext = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
    acc_sum  = acc_q + prod_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wcnt_q        <= '0;
      acnt_q        <= '0;
      acc_q         <= '0;
      acc_out_q     <= '0;
      out_valid_q   <= 1'b0;
      weight_load_q <= 1'b0;
    end else begin
      weight_load_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StLoadW;
            weight_load_q <= 1'b1;
            wcnt_q        <= '0;
          end
        end
        StLoadW: begin
          if (w_valid) begin
            if (wcnt_q == LastIdx) begin
              state_q <= StCompute;
              wcnt_q  <= '0;
              acc_q   <= '0;
              acnt_q  <= '0;
            end else begin
              wcnt_q <= wcnt_q + AW'(1);
            end
          end
        end
        StCompute: begin
          if (act_valid) begin
            acc_q <= acc_sum;
            if (acnt_q == LastIdx) begin
              acc_out_q   <= acc_sum;
              out_valid_q <= 1'b1;
              state_q     <= StOutput;
            end else begin
              acnt_q <= acnt_q + AW'(1);
            end
          end else if (start && (acnt_q == '0)) begin
            // A reload is only allowed between windows; an arriving beat takes priority.
            state_q       <= StLoadW;
            weight_load_q <= 1'b1;
            wcnt_q        <= '0;
          end
        end
        StOutput: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            acnt_q      <= '0;
            state_q     <= StCompute;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign weight_load = weight_load_q;
  assign w_ready     = (state_q == StLoadW);
  assign act_ready   = (state_q == StCompute);
  assign busy        = (state_q != StIdle);
  assign out_valid   = out_valid_q;
  assign acc_out     = acc_out_q;

endmodule

// File: tb/tb_dw_mac_unit.sv
// Self-checking bench for dw_mac_unit against a plain-arithmetic dot-product model.
module tb_dw_mac_unit;

  localparam int DW    = 16;
  localparam int KK    = 9;
  localparam int ACC_W = 40;

  typedef logic signed [DW-1:0] vec_t [KK];

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             weight_load;
  logic [DW-1:0]    w_data = '0;
  logic             w_valid = 1'b0;
  logic             w_ready;
  logic [DW-1:0]    act_data = '0;
  logic             act_valid = 1'b0;
  logic             act_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dw_mac_unit #(
    .DW    (DW),
    .KK    (KK),
    .ACC_W (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .weight_load (weight_load),
    .w_data      (w_data),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .act_data    (act_data),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .acc_out     (acc_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  // Reference: exact signed dot product, reduced modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] ref_dot(input vec_t w, input vec_t a);
    longint s = 0;
    for (int i = 0; i < KK; i++) s += longint'(w[i]) * longint'(a[i]);
    return s[ACC_W-1:0];
  endfunction

  // All driver tasks start and end at a falling edge.
  task automatic begin_load(output logic wl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wl = weight_load;
  endtask

  task automatic drive_weights(input vec_t w, input bit toggle, output int n, output bit tmo);
    int i = 0;
    bit ph = 1'b1;
    bit hs;
    n = 0;
    tmo = 1'b1;
    for (int cyc = 0; cyc < 4 * KK + 8; cyc++) begin
      w_valid = toggle ? ph : 1'b1;
      w_data  = w_valid ? w[i] : DW'($urandom);
      ph = ~ph;
      hs = w_valid && w_ready;
      @(negedge clk);
      if (hs) begin
        i++;
        n++;
      end
      if (i == KK) begin
        tmo = 1'b0;
        break;
      end
    end
    w_valid = 1'b0;
  endtask

  task automatic send_acts(input vec_t a, input int first, input int cnt, input int gap,
                           output bit tmo);
    int i = first;
    bit hs;
    tmo = 1'b1;
    for (int cyc = 0; cyc < 8 * KK + 8; cyc++) begin
      act_valid = ($urandom_range(0, 99) >= gap);
      act_data  = act_valid ? a[i] : DW'($urandom);
      hs = act_valid && act_ready;
      @(negedge clk);
      if (hs) i++;
      if (i == first + cnt) begin
        tmo = 1'b0;
        break;
      end
    end
    act_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (weight_load !== 1'b0) begin errors++; $display("FAIL rst_wl: got %b want 0", weight_load); end
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL rst_w_ready: got %b want 0", w_ready); end
    checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL rst_act_ready: got %b want 0", act_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (acc_out !== '0) begin errors++; $display("FAIL rst_acc_out: got %0h want 0", acc_out); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    vec_t w, a;
    logic wl;
    int n;
    bit tmo;
    for (int i = 0; i < KK; i++) begin
      w[i] = DW'(i + 1);
      a[i] = DW'(1);
    end
    begin_load(wl);
    checks++; if (wl !== 1'b1) begin errors++; $display("FAIL basic_wl: got %b want 1", wl); end
    checks++; if (w_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_loadw: w_ready %b busy %b want 1 1", w_ready, busy); end
    @(negedge clk);
    checks++; if (weight_load !== 1'b0) begin errors++; $display("FAIL basic_wl_pulse: got %b want 0", weight_load); end
    drive_weights(w, 1'b0, n, tmo);
    checks++; if (tmo || act_ready !== 1'b1) begin errors++; $display("FAIL basic_compute: tmo %b act_ready %b want 0 1", tmo, act_ready); end
    send_acts(a, 0, KK, 0, tmo);
    checks++; if (tmo || out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: tmo %b out_valid %b want 0 1", tmo, out_valid); end
    checks++; if (acc_out !== ACC_W'(45)) begin errors++; $display("FAIL basic_sum: got %0d want 45", acc_out); end
    checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL basic_out_act_ready: got %b want 0", act_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || act_ready !== 1'b1) begin errors++; $display("FAIL basic_drain: out_valid %b act_ready %b want 0 1", out_valid, act_ready); end
  endtask

  task automatic test_negative;
    vec_t w, a;
    logic wl;
    logic [ACC_W-1:0] want;
    int n;
    bit tmo;
    for (int i = 0; i < KK; i++) begin
      w[i] = -16'sd1;
      a[i] = 16'sd32767;
    end
    want = -40'sd294903;
    begin_load(wl);
    checks++; if (wl !== 1'b1) begin errors++; $display("FAIL neg_wl: got %b want 1", wl); end
    drive_weights(w, 1'b0, n, tmo);
    send_acts(a, 0, KK, 25, tmo);
    checks++; if (tmo || out_valid !== 1'b1) begin errors++; $display("FAIL neg_valid: tmo %b out_valid %b want 0 1", tmo, out_valid); end
    checks++; if (acc_out !== want) begin errors++; $display("FAIL neg_sum: got %0h want %0h", acc_out, want); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    vec_t w, a;
    logic wl;
    int n;
    bit tmo;
    for (int i = 0; i < KK; i++) begin
      w[i] = DW'(2);
      a[i] = DW'(3);
    end
    begin_load(wl);
    drive_weights(w, 1'b0, n, tmo);
    out_ready = 1'b0;
    send_acts(a, 0, KK, 0, tmo);
    checks++; if (tmo || out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: tmo %b out_valid %b want 0 1", tmo, out_valid); end
    checks++; if (acc_out !== ACC_W'(54)) begin errors++; $display("FAIL bp_sum: got %0d want 54", acc_out); end
    for (int c = 0; c < 5; c++) begin
      act_valid = 1'b1;
      act_data  = DW'(3);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || act_ready !== 1'b0 || acc_out !== ACC_W'(54)) begin
        errors++; $display("FAIL bp_hold: cyc %0d out_valid %b act_ready %b acc %0d want 1 0 54", c, out_valid, act_ready, acc_out);
      end
    end
    act_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", out_valid); end
    send_acts(a, 0, KK, 20, tmo);
    checks++; if (tmo || out_valid !== 1'b1 || acc_out !== ACC_W'(54)) begin errors++; $display("FAIL bp_second: valid %b acc %0d want 1 54", out_valid, acc_out); end
    @(negedge clk);
  endtask

  task automatic test_toggle;
    vec_t w, a;
    logic wl;
    int n;
    bit tmo;
    for (int i = 0; i < KK; i++) begin
      w[i] = DW'(i + 1);
      a[i] = DW'(1);
    end
    begin_load(wl);
    drive_weights(w, 1'b1, n, tmo);
    checks++; if (tmo || n != KK) begin errors++; $display("FAIL tog_count: got %0d beats want %0d", n, KK); end
    checks++; if (w_ready !== 1'b0 || act_ready !== 1'b1) begin errors++; $display("FAIL tog_compute: w_ready %b act_ready %b want 0 1", w_ready, act_ready); end
    send_acts(a, 0, KK, 0, tmo);
    checks++; if (tmo || out_valid !== 1'b1 || acc_out !== ACC_W'(45)) begin errors++; $display("FAIL tog_sum: valid %b acc %0d want 1 45", out_valid, acc_out); end
    @(negedge clk);
  endtask

  task automatic test_start_midwindow;
    vec_t a;
    bit tmo;
    for (int i = 0; i < KK; i++) a[i] = DW'(1);
    send_acts(a, 0, 3, 0, tmo);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (weight_load !== 1'b0 || act_ready !== 1'b1) begin errors++; $display("FAIL mid_start: wl %b act_ready %b want 0 1", weight_load, act_ready); end
    send_acts(a, 3, KK - 3, 0, tmo);
    checks++; if (tmo || out_valid !== 1'b1 || acc_out !== ACC_W'(45)) begin errors++; $display("FAIL mid_sum: valid %b acc %0d want 1 45", out_valid, acc_out); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (weight_load !== 1'b0 || act_ready !== 1'b1) begin errors++; $display("FAIL out_start: wl %b act_ready %b want 0 1", weight_load, act_ready); end
    // Start colliding with a beat at acnt==0: the beat is consumed, the start dropped.
    start = 1'b1;
    act_valid = 1'b1;
    act_data = DW'(1);
    @(negedge clk);
    start = 1'b0;
    act_valid = 1'b0;
    checks++; if (weight_load !== 1'b0 || act_ready !== 1'b1) begin errors++; $display("FAIL collide: wl %b act_ready %b want 0 1", weight_load, act_ready); end
    send_acts(a, 1, KK - 1, 0, tmo);
    checks++; if (tmo || out_valid !== 1'b1 || acc_out !== ACC_W'(45)) begin errors++; $display("FAIL collide_sum: valid %b acc %0d want 1 45", out_valid, acc_out); end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (weight_load !== 1'b1 || w_ready !== 1'b1) begin errors++; $display("FAIL idle_window_start: wl %b w_ready %b want 1 1", weight_load, w_ready); end
  endtask

  task automatic test_reset_mid;
    vec_t w, a;
    logic wl;
    int n;
    bit tmo;
    for (int i = 0; i < KK; i++) begin
      w[i] = DW'(i + 1);
      a[i] = DW'(1);
    end
    drive_weights(w, 1'b0, n, tmo);
    send_acts(a, 0, 4, 0, tmo);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({weight_load, w_ready, act_ready, out_valid, busy} !== 5'b0 || acc_out !== '0) begin
      errors++; $display("FAIL async_rst: wl/wr/ar/ov/busy %b acc %0h want 00000 0", {weight_load, w_ready, act_ready, out_valid, busy}, acc_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    act_valid = 1'b1;
    w_valid = 1'b1;
    repeat (3) @(negedge clk);
    act_valid = 1'b0;
    w_valid = 1'b0;
    checks++; if (busy !== 1'b0 || act_ready !== 1'b0) begin errors++; $display("FAIL no_resume: busy %b act_ready %b want 0 0", busy, act_ready); end
    begin_load(wl);
    drive_weights(w, 1'b0, n, tmo);
    send_acts(a, 0, KK, 0, tmo);
    checks++; if (tmo || out_valid !== 1'b1 || acc_out !== ACC_W'(45)) begin errors++; $display("FAIL post_rst_sum: valid %b acc %0d want 1 45", out_valid, acc_out); end
    @(negedge clk);
  endtask

  task automatic test_random;
    vec_t w, a;
    logic wl;
    logic [ACC_W-1:0] want;
    int n, hold;
    bit tmo;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < KK; i++) w[i] = DW'($urandom);
      begin_load(wl);
      drive_weights(w, it[0], n, tmo);
      for (int win = 0; win < 2; win++) begin
        for (int i = 0; i < KK; i++) a[i] = DW'($urandom);
        want = ref_dot(w, a);
        hold = $urandom_range(0, 3);
        out_ready = (hold == 0);
        send_acts(a, 0, KK, 30, tmo);
        checks++; if (tmo || out_valid !== 1'b1 || acc_out !== want) begin
          errors++; $display("FAIL rand_sum: it %0d win %0d valid %b got %0h want %0h", it, win, out_valid, acc_out, want);
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t w, a;
    logic signed [DW-1:0] s [3*KK];
    logic [ACC_W-1:0] want [3];
    int t [3];
    logic wl;
    int n, idx, nout;
    bit tmo, hs;
    for (int i = 0; i < KK; i++) w[i] = DW'($urandom);
    for (int i = 0; i < 3 * KK; i++) s[i] = DW'($urandom);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < KK; i++) a[i] = s[k*KK + i];
      want[k] = ref_dot(w, a);
    end
    begin_load(wl);
    drive_weights(w, 1'b0, n, tmo);
    idx = 0;
    nout = 0;
    act_valid = 1'b1;
    act_data = s[0];
    for (int cyc = 0; cyc < 60 && nout < 3; cyc++) begin
      hs = act_valid && act_ready;
      @(negedge clk);
      if (hs) idx++;
      if (out_valid) begin
        t[nout] = cyc;
        checks++; if (acc_out !== want[nout]) begin errors++; $display("FAIL b2b_sum: win %0d got %0h want %0h", nout, acc_out, want[nout]); end
        nout++;
      end
      act_valid = (idx < 3 * KK);
      act_data = (idx < 3 * KK) ? s[idx] : '0;
    end
    act_valid = 1'b0;
    checks++; if (nout != 3) begin errors++; $display("FAIL b2b_count: got %0d windows want 3", nout); end
    else begin
      checks++; if (t[1] - t[0] != KK + 1 || t[2] - t[1] != KK + 1) begin
        errors++; $display("FAIL b2b_period: got %0d %0d want %0d", t[1] - t[0], t[2] - t[1], KK + 1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_toggle();
    test_start_midwindow();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
